// File: rtl/uart_tx_frame_ctrl.sv
// Transmit framing and bit-timing controller feeding an LSB-first parallel-to-serial shift register.
// Builds {stop, [even parity], data, start} and paces load/shift strobes at CLKS_PER_BIT clocks per bit.
module uart_tx_frame_ctrl #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 10,
    parameter int PARITY_EN    = 0,
    localparam int FRAME_BITS  = DATA_BITS + 2 + PARITY_EN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_BITS-1:0]  data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic [FRAME_BITS-1:0] frame_word,
    output logic                  load_enable,
    output logic                  shift_enable,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W = $clog2(FRAME_BITS + 1);

    localparam logic [CNT_W-1:0] CLK_TERM = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [CNT_W-1:0]        clk_cnt_r;
    logic [CNT_W-1:0]        clk_cnt_nxt_s;
    logic [BIT_W-1:0]        bit_cnt_r;
    logic [BIT_W-1:0]        bit_cnt_nxt_s;
    logic [FRAME_BITS-1:0]   frame_word_r;
    logic [FRAME_BITS-1:0]   frame_word_nxt_s;
    logic [FRAME_BITS-1:0]   frame_cap_s;
    logic                    clk_term_s;
    logic                    bit_last_s;

    // The parity slot exists only when parity is enabled, so the capture layout is chosen at elaboration.
    generate
        if (PARITY_EN != 0) begin : g_parity
            assign frame_cap_s = {1'b1, even_parity(data_in), data_in, 1'b0};
        end else begin : g_no_parity
            assign frame_cap_s = {1'b1, data_in, 1'b0};
        end
    endgenerate

    assign clk_term_s = (clk_cnt_r == CLK_TERM);
    assign bit_last_s = (bit_cnt_r == BIT_LAST);

    // Next-state and counter update logic; the strobes are decoded separately from registered state.
    always_comb begin
        state_nxt_s      = state_r;
        clk_cnt_nxt_s    = clk_cnt_r;
        bit_cnt_nxt_s    = bit_cnt_r;
        frame_word_nxt_s = frame_word_r;
        case (state_r)
            ST_IDLE: begin
                if (data_valid) begin
                    state_nxt_s      = ST_LOAD;
                    frame_word_nxt_s = frame_cap_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_nxt_s   = ST_SEND;
                clk_cnt_nxt_s = {CNT_W{1'b0}};
                bit_cnt_nxt_s = {BIT_W{1'b0}};
            end
            ST_SEND: begin
                if (clk_term_s) begin
                    clk_cnt_nxt_s = {CNT_W{1'b0}};
                    if (bit_last_s) begin
                        state_nxt_s   = ST_IDLE;
                        bit_cnt_nxt_s = bit_cnt_r;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + BIT_W'(1);
                    end
                end else begin
                    clk_cnt_nxt_s = clk_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counter and frame registers; reset wins over any pending handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            clk_cnt_r    <= {CNT_W{1'b0}};
            bit_cnt_r    <= {BIT_W{1'b0}};
            frame_word_r <= {FRAME_BITS{1'b1}};
        end else begin
            state_r      <= state_nxt_s;
            clk_cnt_r    <= clk_cnt_nxt_s;
            bit_cnt_r    <= bit_cnt_nxt_s;
            frame_word_r <= frame_word_nxt_s;
        end
    end

    // Moore strobe decode: every output depends only on registered state and counters.
    always_comb begin
        data_ready   = 1'b0;
        load_enable  = 1'b0;
        shift_enable = 1'b0;
        busy         = 1'b1;
        tx_done      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                data_ready = 1'b1;
                busy       = 1'b0;
            end
            ST_LOAD: begin
                load_enable = 1'b1;
            end
            ST_SEND: begin
                if (clk_term_s) begin
                    shift_enable = 1'b1;
                    tx_done      = bit_last_s;
                end else begin
                    shift_enable = 1'b0;
                end
            end
            default: begin
                data_ready = 1'b0;
                busy       = 1'b0;
            end
        endcase
    end

    assign frame_word = frame_word_r;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl: three configurations checked every cycle against a
// cycle-phase timing model, with a frame-word scoreboard popped on each expected tx_done.
module tb_uart_tx_frame_ctrl;

    localparam int CC [3] = '{4, 4, 1};
    localparam int FF [3] = '{10, 11, 7};

    logic        clk;
    logic        rst_v [3];
    logic [15:0] din   [3];
    logic        dval  [3];
    logic        rdy   [3];
    logic        ld    [3];
    logic        sh    [3];
    logic        bsy   [3];
    logic        done  [3];
    logic [9:0]  fw_a;
    logic [10:0] fw_b;
    logic [6:0]  fw_c;
    logic [18:0] fw    [3];

    int          n_total;
    int          n_bad;
    int          ph       [3];
    logic [18:0] efw      [3];
    int          done_cnt [3];
    logic [18:0] exp_q    [$];
    int          snap;

    assign fw[0] = {9'd0, fw_a};
    assign fw[1] = {8'd0, fw_b};
    assign fw[2] = {12'd0, fw_c};

    uart_tx_frame_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_a (
        .clk(clk), .rst(rst_v[0]), .data_in(din[0][7:0]), .data_valid(dval[0]),
        .data_ready(rdy[0]), .frame_word(fw_a), .load_enable(ld[0]),
        .shift_enable(sh[0]), .busy(bsy[0]), .tx_done(done[0])
    );

    uart_tx_frame_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_b (
        .clk(clk), .rst(rst_v[1]), .data_in(din[1][7:0]), .data_valid(dval[1]),
        .data_ready(rdy[1]), .frame_word(fw_b), .load_enable(ld[1]),
        .shift_enable(sh[1]), .busy(bsy[1]), .tx_done(done[1])
    );

    uart_tx_frame_ctrl #(.DATA_BITS(5), .CLKS_PER_BIT(1), .PARITY_EN(0)) u_c (
        .clk(clk), .rst(rst_v[2]), .data_in(din[2][4:0]), .data_valid(dval[2]),
        .data_ready(rdy[2]), .frame_word(fw_c), .load_enable(ld[2]),
        .shift_enable(sh[2]), .busy(bsy[2]), .tx_done(done[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [18:0] frame_mask(input int i);
        return (19'd1 << FF[i]) - 19'd1;
    endfunction

    function automatic logic [18:0] build(input int i, input logic [15:0] d);
        case (i)
            0:       return {9'd0, 1'b1, d[7:0], 1'b0};
            1:       return {8'd0, 1'b1, ^d[7:0], d[7:0], 1'b0};
            default: return {12'd0, 1'b1, d[4:0], 1'b0};
        endcase
    endfunction

    // Timing model: ph = cycles since the handshake edge (0 = idle).
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_v[i]) begin
                if (ph[i] != 0 && exp_q.size() > 0) void'(exp_q.pop_back());
                ph[i]  = 0;
                efw[i] = frame_mask(i);
            end else if (ph[i] == 0) begin
                if (dval[i]) begin
                    ph[i]  = 1;
                    efw[i] = build(i, din[i]);
                    exp_q.push_back(efw[i]);
                end
            end else if (ph[i] == 1 + FF[i] * CC[i]) begin
                ph[i] = 0;
            end else begin
                ph[i] = ph[i] + 1;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ready%0d", i), rdy[i], ph[i] == 0);
            chk($sformatf("busy%0d", i), bsy[i], ph[i] != 0);
            chk($sformatf("load%0d", i), ld[i], ph[i] == 1);
            chk($sformatf("shift%0d", i), sh[i],
                ph[i] >= 1 + CC[i] && ph[i] <= 1 + FF[i] * CC[i] && ((ph[i] - 1) % CC[i]) == 0);
            chk($sformatf("done%0d", i), done[i], ph[i] == 1 + FF[i] * CC[i]);
            chk($sformatf("fw%0d", i), fw[i], efw[i]);
            if (ph[i] == 1 + FF[i] * CC[i]) begin
                if (exp_q.size() > 0) chk($sformatf("sb%0d", i), fw[i], exp_q.pop_front());
                else chk($sformatf("sb_empty%0d", i), 32'd0, 32'd1);
            end
            if (done[i]) done_cnt[i]++;
        end
    end

    task automatic send(input int i, input logic [15:0] d);
        @(negedge clk);
        din[i]  = d;
        dval[i] = 1'b1;
        @(negedge clk);
        dval[i] = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        for (int i = 0; i < 3; i++) begin
            rst_v[i]    = 1'b1;
            dval[i]     = 1'b0;
            din[i]      = 16'd0;
            ph[i]       = 0;
            efw[i]      = frame_mask(i);
            done_cnt[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
        @(negedge clk);

        // Basic frame, no parity
        send(0, 16'h00A5);
        chk("t1_fw", {22'd0, fw_a}, 32'h34A);
        repeat (50) @(negedge clk);

        // Even parity, odd and even weight payloads
        send(1, 16'h0007);
        chk("t2_fw07", {21'd0, fw_b}, 32'h60E);
        repeat (50) @(negedge clk);
        send(1, 16'h00A5);
        chk("t2_fwA5", {21'd0, fw_b}, 32'h54A);
        chk("t2_par", {31'd0, fw_b[9]}, 32'd0);
        repeat (50) @(negedge clk);

        // data_valid held: back-to-back frames
        snap = done_cnt[0];
        @(negedge clk);
        din[0]  = 16'h0011;
        dval[0] = 1'b1;
        @(negedge clk);
        din[0]  = 16'h0022;
        repeat (42) @(negedge clk);
        dval[0] = 1'b0;
        repeat (50) @(negedge clk);
        chk("t3_ndone", done_cnt[0] - snap, 32'd2);

        // data_valid pulses while busy are ignored
        snap = done_cnt[0];
        send(0, 16'h003C);
        repeat (8) @(negedge clk);
        din[0]  = 16'h0099;
        dval[0] = 1'b1;
        @(negedge clk);
        dval[0] = 1'b0;
        repeat (10) @(negedge clk);
        dval[0] = 1'b1;
        @(negedge clk);
        dval[0] = 1'b0;
        repeat (40) @(negedge clk);
        chk("t4_ndone", done_cnt[0] - snap, 32'd1);

        // Reset in cycle 20 of a frame
        snap = done_cnt[0];
        send(0, 16'h005A);
        repeat (19) @(negedge clk);
        rst_v[0] = 1'b1;
        @(negedge clk);
        rst_v[0] = 1'b0;
        chk("t5_fw", {22'd0, fw_a}, 32'h3FF);
        chk("t5_ready", {31'd0, rdy[0]}, 32'd1);
        repeat (50) @(negedge clk);
        chk("t5_ndone", done_cnt[0] - snap, 32'd0);

        // Reset together with data_valid: nothing captured
        @(negedge clk);
        rst_v[0] = 1'b1;
        din[0]   = 16'h00FF;
        dval[0]  = 1'b1;
        @(negedge clk);
        rst_v[0] = 1'b0;
        dval[0]  = 1'b0;
        chk("t5b_fw", {22'd0, fw_a}, 32'h3FF);
        repeat (5) @(negedge clk);

        // One clock per bit, 5-bit payload
        snap = done_cnt[2];
        send(2, 16'h0013);
        repeat (15) @(negedge clk);
        chk("t6_ndone", done_cnt[2] - snap, 32'd1);

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
